seg7_to_bcd_encoder: RTL and testbench
======================================

SEG7_TO_BCD_ENCODER -- requirements
Module: seg7_to_bcd_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in  input  7  active-low segment bus, bit0=a ... bit6=g, asynchronous to clk.
REQ-005 SHALL have port out_ready  input  1  consumer accepts the current result.
REQ-006 SHALL have port out_valid  output  1  result held on out_* is valid.
REQ-007 SHALL have port out_digit  output  4  decoded value; 4'hF when not a digit.
REQ-008 SHALL have port out_dash  output  1  accepted pattern was dash 7'b0111111.
REQ-009 SHALL have port out_err  output  1  accepted pattern not in the table.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when an event is dropped.

Function
REQ-011 SHALL pass seg_in through a 2-flop synchronizer; all comparisons use the synchronized value seg_s.
REQ-012 SHALL decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bit6..bit0).
REQ-013 SHALL run FSM IDLE/SETTLE/HOLD; IDLE: seg_s blank (7'b1111111); SETTLE: counting stability; HOLD: pattern accepted, waiting for change.
REQ-014 SHALL go to SETTLE with counter=1 on any cycle seg_s differs from its previous value and is non-blank; to IDLE when seg_s becomes blank.
REQ-015 SHALL, in SETTLE, increment an 8-bit counter each unchanged cycle; on reaching STABLE_CYCLES generate one event and enter HOLD.
REQ-016 SHALL suppress the event when the settled pattern equals the last accepted pattern and no blank has intervened (glitch re-settle).
REQ-017 SHALL load out_digit/out_dash/out_err and set out_valid on the edge following the event; latency seg_s change to out_valid = STABLE_CYCLES+1 clk, seg_in to out_valid = STABLE_CYCLES+3 clk.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0; clear out_valid on the edge where out_valid=1 and out_ready=1.
REQ-019 SHALL, on an event coinciding with accept (out_valid=1, out_ready=1), load the new result with out_valid remaining 1.
REQ-020 SHALL, on an event while out_valid=1 and out_ready=0, drop the event, keep the old result and pulse overrun for one cycle.
REQ-021 SHALL, for dash, output out_digit=4'hF, out_dash=1, out_err=0; for unlisted non-blank patterns out_digit=4'hF, out_err=1, out_dash=0.
REQ-022 SHALL never produce an event for the blank pattern; blank clears the last-accepted pattern to blank.

Reset
REQ-023 SHALL on rst_n=0 immediately set FSM=IDLE, counter=0, synchronizer and last-accepted=7'b1111111, out_valid=0, out_digit=4'hF, out_dash=0, out_err=0, overrun=0.
REQ-024 SHALL discard any in-progress SETTLE count and pending result on reset; first event after release requires full STABLE_CYCLES.

Configuration
REQ-025 SHALL, with SEG7_ENC_HEX_EN defined, also decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 to 4'hA..4'hF with out_err=0.
REQ-026 SHALL, without SEG7_ENC_HEX_EN, treat those six patterns as unlisted (out_err=1).

Structure
REQ-027 SHALL place segment pattern constants (digits, dash, blank, hex letters) and the STABLE_CYCLES default in shared package seg7_pkg, also used by the display decoder.
REQ-028 SHALL implement the pure pattern lookup as combinational sub-module seg7_pattern_lookup (7-bit in; digit, dash, err out); FSM, counter and handshake stay in the top.

Verification
REQ-029 SHALL cover: seg_in=7'b0110000 held, out_ready=1, STABLE_CYCLES=4 -> out_valid high 7 clk after change, out_digit=3, out_dash=0, out_err=0.
REQ-030 SHALL cover: 7'b0010010 for 2 cycles then 7'b0000000 held -> single event out_digit=8, no event for 5.
REQ-031 SHALL cover: digit 1 accepted, out_ready=0, then digit 2 settled -> overrun pulses once, out_digit stays 1 until accept.
REQ-032 SHALL cover: 7'b0111111 held -> out_dash=1, out_digit=4'hF; 7'b0001000 held -> out_err=1 without macro, out_digit=4'hA with SEG7_ENC_HEX_EN.
REQ-033 SHALL cover: digit 7 accepted, blank 10 cycles, digit 7 again -> second event produced; digit 7 with 1-cycle glitch -> no second event.
REQ-034 SHALL cover: rst_n asserted mid-SETTLE with out_valid=1 -> outputs at reset values same cycle, no event until STABLE_CYCLES after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (bit6=g .. bit0=a,
// active-low), the default debounce depth, the encoder FSM state type and
// the decoded-result record. Also used by the display decoder.
package seg7_pkg;

    // Default number of identical synchronized samples before acceptance
    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    // Decimal digit patterns
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Special patterns
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex letter patterns (A, b, C, d, E, F)
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    // Digit code reported for anything that is not a digit
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    // Encoder debounce FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seg7_state_e;

    // Decoded result as held on the output port
    typedef struct packed {
        logic [3:0] digit;
        logic       dash;
        logic       err;
    } seg7_result_t;

    localparam seg7_result_t RESULT_RESET = '{digit: 4'hF, dash: 1'b0, err: 1'b0};

    // True when no segment is lit
    function automatic logic seg_is_blank(input logic [6:0] pat);
        return (pat == SEG_BLANK);
    endfunction

endpackage : seg7_pkg

// File: rtl/seg7_pattern_lookup.sv
// Pure combinational seven-segment pattern lookup.
// Optional feature: define SEG7_ENC_HEX_EN to also decode A..F to 4'hA..4'hF;
// without it those six letters are reported as unlisted (err=1).
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_pat,
    output logic [3:0] digit,
    output logic       dash,
    output logic       err
);

    // Map one active-low segment pattern to digit / dash / error flags
    always_comb begin
        digit = DIGIT_NONE;
        dash  = 1'b0;
        err   = 1'b0;
        case (seg_pat)
            SEG_0:     digit = 4'h0;
            SEG_1:     digit = 4'h1;
            SEG_2:     digit = 4'h2;
            SEG_3:     digit = 4'h3;
            SEG_4:     digit = 4'h4;
            SEG_5:     digit = 4'h5;
            SEG_6:     digit = 4'h6;
            SEG_7:     digit = 4'h7;
            SEG_8:     digit = 4'h8;
            SEG_9:     digit = 4'h9;
            SEG_DASH:  dash  = 1'b1;
            // Blank never produces an event; report it as a neutral non-digit
            SEG_BLANK: digit = DIGIT_NONE;
`ifdef SEG7_ENC_HEX_EN
            SEG_HEX_A: digit = 4'hA;
            SEG_HEX_B: digit = 4'hB;
            SEG_HEX_C: digit = 4'hC;
            SEG_HEX_D: digit = 4'hD;
            SEG_HEX_E: digit = 4'hE;
            SEG_HEX_F: digit = 4'hF;
`endif
            default:   err   = 1'b1;
        endcase
    end

endmodule : seg7_pattern_lookup

// File: rtl/seg7_to_bcd_encoder.sv
// Seven-segment to BCD encoder: synchronizes an asynchronous active-low
// segment bus, debounces it for STABLE_CYCLES samples, decodes the settled
// pattern and presents the result on a valid/ready output with overrun flag.
// Optional feature: SEG7_ENC_HEX_EN (hex letter decode, see seg7_pattern_lookup).
module seg7_to_bcd_encoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_dash,
    output logic       out_err,
    output logic       overrun
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    // Synchronizer and change-detection history
    logic [6:0]   sync1_q;
    logic [6:0]   seg_s_q;
    logic [6:0]   seg_prev_q;

    // Debounce state
    seg7_state_e  state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [6:0]   last_q, last_d;

    // Output holding registers
    seg7_result_t res_q, res_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;

    // Combinational helpers
    logic         blank_s;
    logic         changed_s;
    logic         settle_done_s;
    logic         event_s;
    seg7_result_t lookup_s;

    assign blank_s   = seg_is_blank(seg_s_q);
    assign changed_s = (seg_s_q != seg_prev_q);

    seg7_pattern_lookup u_lookup (
        .seg_pat (seg_s_q),
        .digit   (lookup_s.digit),
        .dash    (lookup_s.dash),
        .err     (lookup_s.err)
    );

    // Two-flop synchronizer plus one-cycle history of the synchronized bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= SEG_BLANK;
            seg_s_q    <= SEG_BLANK;
            seg_prev_q <= SEG_BLANK;
        end else begin
            sync1_q    <= seg_in;
            seg_s_q    <= sync1_q;
            seg_prev_q <= seg_s_q;
        end
    end

    // Debounce FSM next state, stability counter and event generation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        settle_done_s = 1'b0;
        event_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!blank_s && changed_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (blank_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (changed_s) begin
                    cnt_d   = 8'd1;
                end else if (cnt_q >= STABLE_LIMIT) begin
                    state_d       = ST_HOLD;
                    settle_done_s = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (blank_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (changed_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // A blank forgets the last pattern so the same digit can be re-entered;
        // a re-settle onto the last pattern without a blank is a glitch.
        if (blank_s) begin
            last_d = SEG_BLANK;
        end else if (settle_done_s && (seg_s_q != last_q)) begin
            event_s = 1'b1;
            last_d  = seg_s_q;
        end else begin
            last_d = last_q;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Output handshake: load, hold, clear on accept, or drop with overrun
    always_comb begin
        res_d     = res_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (event_s) begin
            if (!valid_q || out_ready) begin
                res_d   = lookup_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= RESULT_RESET;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            res_q     <= res_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign out_digit = res_q.digit;
    assign out_dash  = res_q.dash;
    assign out_err   = res_q.err;
    assign overrun   = overrun_q;

endmodule : seg7_to_bcd_encoder

// File: tb/tb_seg7_to_bcd_encoder.sv
// Directed self-checking bench for seg7_to_bcd_encoder (STABLE_CYCLES = 4).
// Inputs change and outputs are sampled on the falling clock edge; a value
// driven at one falling edge reaches out_valid 7 rising edges later.
module tb_seg7_to_bcd_encoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_dash;
    logic       out_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEG7_ENC_HEX_EN
    localparam logic [3:0] EXP_A_DIGIT = 4'hA;
    localparam logic       EXP_A_ERR   = 1'b0;
`else
    localparam logic [3:0] EXP_A_DIGIT = 4'hF;
    localparam logic       EXP_A_ERR   = 1'b1;
`endif

    seg7_to_bcd_encoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_dash  (out_dash),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_in    = 7'b1111111;
        out_ready = 1'b1;
        ticks(2);
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_digit",   32'(out_digit), 32'hF);
        chk("rst_dash",    32'(out_dash),  32'd0);
        chk("rst_err",     32'(out_err),   32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Digit 3: latency 7 clocks, then accepted and cleared
        seg_in = 7'b0110000;
        ticks(6);
        chk("d3_early_valid", 32'(out_valid), 32'd0);
        ticks(1);
        chk("d3_valid", 32'(out_valid), 32'd1);
        chk("d3_digit", 32'(out_digit), 32'h3);
        chk("d3_dash",  32'(out_dash),  32'd0);
        chk("d3_err",   32'(out_err),   32'd0);
        ticks(1);
        chk("d3_accept_clear", 32'(out_valid), 32'd0);
        ticks(5);
        chk("d3_no_repeat", 32'(out_valid), 32'd0);

        // Short-lived 5 then steady 8: only the 8 produces an event
        seg_in = 7'b0010010;
        ticks(2);
        seg_in = 7'b0000000;
        ticks(6);
        chk("d5_no_event", 32'(out_valid), 32'd0);
        ticks(1);
        chk("d8_valid", 32'(out_valid), 32'd1);
        chk("d8_digit", 32'(out_digit), 32'h8);
        ticks(1);
        chk("d8_clear", 32'(out_valid), 32'd0);

        // Dash
        seg_in = 7'b0111111;
        ticks(7);
        chk("dash_valid", 32'(out_valid), 32'd1);
        chk("dash_flag",  32'(out_dash),  32'd1);
        chk("dash_digit", 32'(out_digit), 32'hF);
        chk("dash_err",   32'(out_err),   32'd0);
        ticks(1);

        // Letter A: error without hex decode, 4'hA with it
        seg_in = 7'b0001000;
        ticks(7);
        chk("hexA_valid", 32'(out_valid), 32'd1);
        chk("hexA_digit", 32'(out_digit), 32'(EXP_A_DIGIT));
        chk("hexA_err",   32'(out_err),   32'(EXP_A_ERR));
        chk("hexA_dash",  32'(out_dash),  32'd0);
        ticks(1);

        // Unlisted pattern
        seg_in = 7'b1010101;
        ticks(7);
        chk("junk_valid", 32'(out_valid), 32'd1);
        chk("junk_err",   32'(out_err),   32'd1);
        chk("junk_digit", 32'(out_digit), 32'hF);
        chk("junk_dash",  32'(out_dash),  32'd0);
        ticks(1);

        // Overrun: digit 1 held unaccepted, digit 2 settles and is dropped
        out_ready = 1'b0;
        seg_in = 7'b1111001;
        ticks(7);
        chk("d1_valid", 32'(out_valid), 32'd1);
        chk("d1_digit", 32'(out_digit), 32'h1);
        seg_in = 7'b0100100;
        ticks(6);
        chk("ovr_before", 32'(overrun), 32'd0);
        ticks(1);
        chk("ovr_pulse",      32'(overrun),   32'd1);
        chk("ovr_keep_valid", 32'(out_valid), 32'd1);
        chk("ovr_keep_digit", 32'(out_digit), 32'h1);
        ticks(1);
        chk("ovr_one_cycle", 32'(overrun),   32'd0);
        chk("ovr_hold_digit", 32'(out_digit), 32'h1);
        ticks(3);
        chk("ovr_no_second", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        ticks(1);
        chk("ovr_accept_clear", 32'(out_valid), 32'd0);
        chk("ovr_accept_digit", 32'(out_digit), 32'h1);

        // Event coinciding with accept: new result loads, valid stays high
        out_ready = 1'b0;
        seg_in = 7'b0011001;
        ticks(7);
        chk("d4_digit", 32'(out_digit), 32'h4);
        seg_in = 7'b0000010;
        ticks(6);
        out_ready = 1'b1;
        ticks(1);
        chk("coin_valid",   32'(out_valid), 32'd1);
        chk("coin_digit",   32'(out_digit), 32'h6);
        chk("coin_overrun", 32'(overrun),   32'd0);
        ticks(1);
        chk("coin_clear", 32'(out_valid), 32'd0);

        // Digit 7, blank for 10 cycles, digit 7 again: second event
        seg_in = 7'b1111000;
        ticks(7);
        chk("d7a_digit", 32'(out_digit), 32'h7);
        ticks(1);
        seg_in = 7'b1111111;
        ticks(10);
        seg_in = 7'b1111000;
        ticks(7);
        chk("d7b_valid", 32'(out_valid), 32'd1);
        chk("d7b_digit", 32'(out_digit), 32'h7);
        ticks(1);

        // One-cycle glitch then back to 7: no new event
        seg_in = 7'b0000000;
        ticks(1);
        seg_in = 7'b1111000;
        ticks(7);
        chk("glitch_no_event", 32'(out_valid), 32'd0);
        ticks(3);
        chk("glitch_no_event_late", 32'(out_valid), 32'd0);

        // Reset mid-settle with a pending result
        out_ready = 1'b0;
        seg_in = 7'b0010000;
        ticks(7);
        chk("d9_valid", 32'(out_valid), 32'd1);
        chk("d9_digit", 32'(out_digit), 32'h9);
        seg_in = 7'b1000000;
        ticks(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(out_valid), 32'd0);
        chk("mid_rst_digit",   32'(out_digit), 32'hF);
        chk("mid_rst_dash",    32'(out_dash),  32'd0);
        chk("mid_rst_err",     32'(out_err),   32'd0);
        chk("mid_rst_overrun", 32'(overrun),   32'd0);
        out_ready = 1'b1;
        ticks(1);
        rst_n = 1'b1;
        ticks(6);
        chk("post_rst_early", 32'(out_valid), 32'd0);
        ticks(1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_digit", 32'(out_digit), 32'h0);
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seg7_to_bcd_encoder
